lfu_counter_bank: RTL

Holds four WIDTH-bit use-frequency counters, one per replacement slot, and presents them on a, b, c, d to the minimum-position finder, which selects the least-frequently-used slot. Access and fill events arrive through a single valid/ready handshake. An access to a saturated counter starts a multi-cycle aging pass that halves every counter before the pending increment is applied. The block sits directly upstream of the minimum finder, and its outputs wire straight to that block's a, b, c, d inputs.

---
 rtl/lfu_counter_bank.sv | 85 ++++++++
 1 files changed

// File: rtl/lfu_counter_bank.sv
// Four per-slot use-frequency counters feeding the LFU minimum finder.
// A saturated access triggers a four-cycle halving pass before the increment.
module lfu_counter_bank #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_valid,
  input  logic [1:0]       acc_idx,
  input  logic             fill_valid,
  input  logic [1:0]       fill_idx,
  output logic             ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             age_done
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic {IDLE, AGE} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       pidx;
  logic [WIDTH-1:0] cnt [4];

  logic             fill_go;
  logic             acc_go;
  logic [WIDTH-1:0] aged;

  assign ready = (state == IDLE);

  // A fill to the same slot as a concurrent access discards the access.
  always_comb begin
    fill_go = fill_valid && ready;
    acc_go  = acc_valid && ready &&
              !(fill_valid && (fill_idx == acc_idx));
  end

  assign aged = (cnt[ptr] >> 1) + ((ptr == pidx) ? ONE : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      pidx     <= 2'd0;
      age_done <= 1'b0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      age_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fill_go) cnt[fill_idx] <= ONE;
          if (acc_go) begin
            if (cnt[acc_idx] == MAX) begin
              pidx  <= acc_idx;
              ptr   <= 2'd0;
              state <= AGE;
            end else begin
              cnt[acc_idx] <= cnt[acc_idx] + ONE;
            end
          end
        end
        AGE: begin
          cnt[ptr] <= aged;
          ptr      <= ptr + 2'd1;
          if (ptr == 2'd3) begin
            age_done <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign a = cnt[0];
  assign b = cnt[1];
  assign c = cnt[2];
  assign d = cnt[3];

endmodule
